// File: rtl/cpu_trap_ctrl.sv
// Trap sequencer sitting between the pipeline and the supervisor CSR file.
// Accepts one trap (exception, SRET or interrupt) at a time, drains and
// flushes the pipeline, strobes the CSR file, then redirects fetch.
module cpu_trap_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exc_req_i,
  input  logic [31:0] exc_cause_in_i,
  input  logic [31:0] exc_pc_in_i,
  input  logic [31:0] exc_value_in_i,
  input  logic        sret_req_i,
  input  logic        inst_boundary_i,
  input  logic [31:0] next_pc_i,
  input  logic        has_intr_i,
  input  logic        pipe_idle_i,
  input  logic [31:0] exc_handler_addr_i,
  input  logic [31:0] exc_continue_addr_i,
  input  logic        redir_ready_i,
  output logic        pipe_stall_o,
  output logic        pipe_flush_o,
  output logic        csr_exception_o,
  output logic        csr_interrupt_o,
  output logic        csr_exc_leave_o,
  output logic [31:0] csr_exc_cause_o,
  output logic [31:0] csr_exc_pc_o,
  output logic [31:0] csr_exc_value_o,
  output logic        redir_valid_o,
  output logic [31:0] redir_addr_o,
  output logic        busy_o,
  output logic        drain_timeout_o
);

  localparam int unsigned CntW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StCommit,
    StRedirect
  } state_e;

  typedef enum logic [1:0] {
    KindExc,
    KindInt,
    KindRet
  } kind_e;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [31:0]     cause_q, cause_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     value_q, value_d;
  logic [CntW-1:0] drainCnt_q, drainCnt_d;
  logic            drainTimeout_q, drainTimeout_d;
  logic [31:0]     redirAddr_q, redirAddr_d;
  logic            redirFirst_q, redirFirst_d;
  logic            flushNow;
  logic [31:0]     targetAddr;

  // Redirect target follows the CSR file: handler for entries, saved EPC for SRET.
  always_comb begin
    targetAddr = 32'h0;
    if (kind_q == KindRet) begin
      targetAddr = exc_continue_addr_i & 32'hFFFF_FFFC;
    end else begin
      targetAddr = exc_handler_addr_i & 32'hFFFF_FFFC;
    end
  end

  // Next-state logic: arbitration in IDLE, drain counting, commit and redirect handshake.
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
    value_d        = value_q;
    drainCnt_d     = drainCnt_q;
    drainTimeout_d = drainTimeout_q;
    redirAddr_d    = redirAddr_q;
    redirFirst_d   = 1'b0;
    flushNow       = 1'b0;
    case (state_q)
      StIdle: begin
        if (exc_req_i) begin
          kind_d     = KindExc;
          cause_d    = exc_cause_in_i;
          pc_d       = exc_pc_in_i;
          value_d    = exc_value_in_i;
          flushNow   = 1'b1;
          drainCnt_d = '0;
          state_d    = StDrain;
        end else if (sret_req_i) begin
          kind_d     = KindRet;
          flushNow   = 1'b1;
          drainCnt_d = '0;
          state_d    = StDrain;
        end else if (has_intr_i && inst_boundary_i) begin
          kind_d     = KindInt;
          cause_d    = 32'h0;
          pc_d       = next_pc_i;
          value_d    = 32'h0;
          flushNow   = 1'b1;
          drainCnt_d = '0;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        drainCnt_d = drainCnt_q + CntW'(1);
        if (pipe_idle_i) begin
          state_d = StCommit;
        end else if (drainCnt_q == CntMax) begin
          state_d        = StCommit;
          drainTimeout_d = 1'b1;
        end
      end
      StCommit: begin
        state_d      = StRedirect;
        redirFirst_d = 1'b1;
      end
      StRedirect: begin
        if (redirFirst_q) begin
          redirAddr_d = targetAddr;
        end
        if (redir_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latch registers, cleared immediately when reset is asserted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      kind_q         <= KindExc;
      cause_q        <= 32'h0;
      pc_q           <= 32'h0;
      value_q        <= 32'h0;
      drainCnt_q     <= '0;
      drainTimeout_q <= 1'b0;
      redirAddr_q    <= 32'h0;
      redirFirst_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      cause_q        <= cause_d;
      pc_q           <= pc_d;
      value_q        <= value_d;
      drainCnt_q     <= drainCnt_d;
      drainTimeout_q <= drainTimeout_d;
      redirAddr_q    <= redirAddr_d;
      redirFirst_q   <= redirFirst_d;
    end
  end

  // The first REDIRECT cycle shows the freshly updated CSR value; later cycles hold the captured copy.
  always_comb begin
    redir_addr_o = 32'h0;
    if (state_q == StRedirect) begin
      redir_addr_o = redirFirst_q ? targetAddr : redirAddr_q;
    end
  end

  assign pipe_flush_o    = flushNow && rst_ni;
  assign busy_o          = (state_q != StIdle);
  assign pipe_stall_o    = (state_q != StIdle);
  assign csr_exception_o = (state_q == StCommit) && (kind_q != KindRet);
  assign csr_interrupt_o = (state_q == StCommit) && (kind_q == KindInt);
  assign csr_exc_leave_o = (state_q == StCommit) && (kind_q == KindRet);
  assign csr_exc_cause_o = cause_q;
  assign csr_exc_pc_o    = pc_q;
  assign csr_exc_value_o = value_q;
  assign redir_valid_o   = (state_q == StRedirect);
  assign drain_timeout_o = drainTimeout_q;

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// Scoreboard bench for the trap sequencer: the driver pushes the expected
// trap outcome when it issues a request, a monitor pops on each redirect.
module tb_cpu_trap_ctrl;

  localparam int DrainTimeout = 16;
  localparam int KExc = 0;
  localparam int KInt = 1;
  localparam int KRet = 2;

  logic        clk;
  logic        rst_n;
  logic        exc_req;
  logic [31:0] exc_cause_in;
  logic [31:0] exc_pc_in;
  logic [31:0] exc_value_in;
  logic        sret_req;
  logic        inst_boundary;
  logic [31:0] next_pc;
  logic        has_intr;
  logic        pipe_idle;
  logic [31:0] exc_handler_addr;
  logic [31:0] exc_continue_addr;
  logic        redir_ready;
  logic        pipe_stall;
  logic        pipe_flush;
  logic        csr_exception;
  logic        csr_interrupt;
  logic        csr_exc_leave;
  logic [31:0] csr_exc_cause;
  logic [31:0] csr_exc_pc;
  logic [31:0] csr_exc_value;
  logic        redir_valid;
  logic [31:0] redir_addr;
  logic        busy;
  logic        drain_timeout;

  typedef struct {
    int          kind;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] value;
    logic [31:0] redir;
    int          acceptCyc;
    int          commitDelay;
    bit          sticky;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        monE;
  int          nCompared = 0;
  int          nMismatch = 0;
  int          cyc = 0;
  bit          monEnable = 0;
  bit          holdReady = 0;
  logic [31:0] mdlCause = 0;
  logic [31:0] mdlPc = 0;
  logic [31:0] mdlValue = 0;
  bit          mdlSticky = 0;

  cpu_trap_ctrl #(.DRAIN_TIMEOUT(DrainTimeout)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .exc_req_i           (exc_req),
    .exc_cause_in_i      (exc_cause_in),
    .exc_pc_in_i         (exc_pc_in),
    .exc_value_in_i      (exc_value_in),
    .sret_req_i          (sret_req),
    .inst_boundary_i     (inst_boundary),
    .next_pc_i           (next_pc),
    .has_intr_i          (has_intr),
    .pipe_idle_i         (pipe_idle),
    .exc_handler_addr_i  (exc_handler_addr),
    .exc_continue_addr_i (exc_continue_addr),
    .redir_ready_i       (redir_ready),
    .pipe_stall_o        (pipe_stall),
    .pipe_flush_o        (pipe_flush),
    .csr_exception_o     (csr_exception),
    .csr_interrupt_o     (csr_interrupt),
    .csr_exc_leave_o     (csr_exc_leave),
    .csr_exc_cause_o     (csr_exc_cause),
    .csr_exc_pc_o        (csr_exc_pc),
    .csr_exc_value_o     (csr_exc_value),
    .redir_valid_o       (redir_valid),
    .redir_addr_o        (redir_addr),
    .busy_o              (busy),
    .drain_timeout_o     (drain_timeout)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time the commit strobe relative to the accept cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] kindBits(input int kind);
    case (kind)
      KExc:    return 32'b100;
      KInt:    return 32'b110;
      default: return 32'b001;
    endcase
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ctrl"}, {24'd0, pipe_stall, pipe_flush, csr_exception, csr_interrupt,
                                 csr_exc_leave, redir_valid, busy, drain_timeout}, 32'h0);
    checkOutput({tag, " cause"}, csr_exc_cause, 32'h0);
    checkOutput({tag, " pc"}, csr_exc_pc, 32'h0);
    checkOutput({tag, " value"}, csr_exc_value, 32'h0);
    checkOutput({tag, " redir_addr"}, redir_addr, 32'h0);
  endtask

  // Fetch readiness toggles randomly unless a test pins it low.
  initial begin
    redir_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      redir_ready = holdReady ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: checks commit strobes against the queue head and pops on redirect handshake.
  initial begin
    bit          pv;
    logic [31:0] pa;
    pv = 1'b0;
    pa = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n || !monEnable) begin
        pv = 1'b0;
      end else begin
        if (csr_exception || csr_exc_leave) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpected commit strobe", 32'h1, 32'h0);
          end else begin
            monE = sbQ[0];
            checkOutput("commit kind", {29'd0, csr_exception, csr_interrupt, csr_exc_leave}, kindBits(monE.kind));
            checkOutput("commit cause", csr_exc_cause, monE.cause);
            checkOutput("commit pc", csr_exc_pc, monE.pc);
            checkOutput("commit value", csr_exc_value, monE.value);
            checkOutput("commit cycle", cyc, monE.acceptCyc + monE.commitDelay);
            checkOutput("commit sticky timeout", {31'd0, drain_timeout}, {31'd0, monE.sticky});
            checkOutput("commit stall/busy", {30'd0, pipe_stall, busy}, 32'h3);
          end
        end
        if (redir_valid) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpected redirect", 32'h1, 32'h0);
          end else begin
            if (!pv) checkOutput("redir addr", redir_addr, sbQ[0].redir);
            else     checkOutput("redir addr hold", redir_addr, pa);
            if (redir_ready) begin
              void'(sbQ.pop_front());
              pv = 1'b0;
            end else begin
              pv = 1'b1;
              pa = redir_addr;
            end
          end
        end else begin
          pv = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input bit exc, input bit sret, input bit intr, input bit bnd,
                               input logic [31:0] cause, input logic [31:0] pc,
                               input logic [31:0] value, input logic [31:0] npc,
                               input logic [31:0] handler, input logic [31:0] cont,
                               input int dw, input bit waitDone);
    int   guard;
    int   kind;
    bit   acc;
    exp_t e;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (busy && guard < 200);
    if (busy) begin
      checkOutput("idle wait timeout", {31'd0, busy}, 32'h0);
      return;
    end
    exc_req           = exc;
    sret_req          = sret;
    has_intr          = intr;
    inst_boundary     = bnd;
    exc_cause_in      = cause;
    exc_pc_in         = pc;
    exc_value_in      = value;
    next_pc           = npc;
    exc_handler_addr  = handler;
    exc_continue_addr = cont;
    pipe_idle         = (dw == 0);
    acc  = 1'b1;
    kind = KExc;
    if (exc) begin
      kind = KExc;
      mdlCause = cause; mdlPc = pc; mdlValue = value;
    end else if (sret) begin
      kind = KRet;
    end else if (intr && bnd) begin
      kind = KInt;
      mdlCause = 32'h0; mdlPc = npc; mdlValue = 32'h0;
    end else begin
      acc = 1'b0;
    end
    if (acc) begin
      if (dw >= DrainTimeout) mdlSticky = 1'b1;
      e.kind        = kind;
      e.cause       = mdlCause;
      e.pc          = mdlPc;
      e.value       = mdlValue;
      e.redir       = ((kind == KRet) ? cont : handler) & 32'hFFFF_FFFC;
      e.acceptCyc   = cyc;
      e.commitDelay = ((dw < DrainTimeout - 1) ? dw : DrainTimeout - 1) + 2;
      e.sticky      = mdlSticky;
      sbQ.push_back(e);
    end
    @(negedge clk);
    checkOutput("flush on accept", {31'd0, pipe_flush}, {31'd0, acc});
    @(posedge clk);
    #1;
    exc_req = 1'b0; sret_req = 1'b0; has_intr = 1'b0; inst_boundary = 1'b0;
    exc_cause_in = $urandom; exc_pc_in = $urandom; exc_value_in = $urandom; next_pc = $urandom;
    if (!acc) begin
      checkOutput("no accept stays idle", {31'd0, busy}, 32'h0);
      return;
    end
    checkOutput("busy after accept", {30'd0, busy, pipe_flush}, 32'h2);
    for (int k = 0; k < dw; k++) begin
      pipe_idle = 1'b0;
      exc_cause_in = $urandom;
      @(posedge clk);
      #1;
    end
    pipe_idle = 1'b1;
    if (waitDone) begin
      guard = 0;
      while (busy && guard < 200) begin
        @(posedge clk);
        #1;
        guard++;
      end
      if (busy) checkOutput("completion timeout", {31'd0, busy}, 32'h0);
    end
  endtask

  // Main sequence: reset checks, directed traps, random traps, reset mid-redirect.
  initial begin
    int guard;
    rst_n = 1'b0;
    exc_req = 1'b1; sret_req = 1'b0; has_intr = 1'b0; inst_boundary = 1'b0;
    exc_cause_in = 32'h0; exc_pc_in = 32'h0; exc_value_in = 32'h0; next_pc = 32'h0;
    pipe_idle = 1'b1; exc_handler_addr = 32'h0; exc_continue_addr = 32'h0;
    #12;
    checkAllZero("reset state");
    exc_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    monEnable = 1'b1;

    applyStimulus(1, 0, 0, 0, 32'd2, 32'h100, 32'hDEAD, 32'h0, 32'h2001, 32'h0, 0, 1);
    applyStimulus(0, 0, 1, 1, 32'h55, 32'h77, 32'h99, 32'h44, 32'h3000, 32'h0, 0, 1);
    applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3000, 32'h108, 0, 1);
    applyStimulus(1, 1, 1, 1, 32'd5, 32'h200, 32'h1234, 32'h204, 32'h4003, 32'h300, 2, 1);
    applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4003, 32'h30A, 1, 1);
    applyStimulus(0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h80, 32'h5000, 32'h0, 0, 1);
    applyStimulus(1, 0, 0, 0, 32'd7, 32'h500, 32'hBEEF, 32'h0, 32'h6002, 32'h0, 20, 1);
    applyStimulus(0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h600, 32'h7000, 32'h0, 15, 1);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 18), 1);
    end

    holdReady = 1'b1;
    applyStimulus(1, 0, 0, 0, 32'd9, 32'h900, 32'h1111, 32'h0, 32'h8001, 32'h0, 0, 0);
    guard = 0;
    while (!redir_valid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("redirect reached", {31'd0, redir_valid}, 32'h1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("reset mid-redirect");
    sbQ.delete();
    mdlCause = 0; mdlPc = 0; mdlValue = 0; mdlSticky = 0;
    @(negedge clk);
    rst_n = 1'b1;
    holdReady = 1'b0;

    applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h400, 0, 1);
    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
